// File: rtl/cpu_pkg.sv
// Shared types and defaults for the register-file writeback path.
package cpu_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_idx_t;

  localparam int LDQ_DEPTH_DEF   = 4;
  localparam int LD_MAX_WAIT_DEF = 3;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LOAD
  } wb_src_t;

endpackage

// File: rtl/ld_tag_fifo.sv
// In-order FIFO of destination indices for loads still waiting on memory.
module ld_tag_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = LDQ_DEPTH_DEF,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [4:0]    push_data,
  input  logic          pop,
  output logic [4:0]    head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  reg_idx_t        mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Arbitrates the single register-file write port between ALU results and
// buffered load returns, and tracks in-flight load destinations for hazards.
module writeback_arbiter
  import cpu_pkg::*;
#(
  parameter int LDQ_DEPTH   = LDQ_DEPTH_DEF,
  parameter int LD_MAX_WAIT = LD_MAX_WAIT_DEF
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        alu_wen,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_wdata,
  output logic        alu_ready,
  input  logic        ld_issue,
  input  logic [4:0]  ld_rd,
  output logic        ld_issue_ready,
  input  logic        ld_done,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  output logic        hazard,
  output logic        reg_write,
  output logic [4:0]  write_index,
  output logic [31:0] write_data,
  output logic [31:0] busy_vec,
  output logic        protocol_err
);

  localparam int CW = $clog2(LDQ_DEPTH + 1);
  localparam int WW = (LD_MAX_WAIT < 1) ? 1 : $clog2(LD_MAX_WAIT + 1);

  reg_idx_t      fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  logic          lbuf_valid;
  reg_idx_t      lbuf_rd;
  word_t         lbuf_data;
  logic [WW-1:0] wait_cnt;
  logic          lbuf_wins;

  wb_src_t       wb_sel;
  wb_src_t       wb_src_q;
  logic [31:0]   busy;
  logic [31:0]   busy_next;

  assign ld_issue_ready = (fifo_count < CW'(LDQ_DEPTH));
  assign push           = ld_issue & ~fifo_full;
  assign pop            = ld_done & ld_ready & ~fifo_empty;

  ld_tag_fifo #(.DEPTH(LDQ_DEPTH)) u_tag_fifo (
    .clk       (clk),
    .rst       (RST),
    .push      (push),
    .push_data (ld_rd),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A starved load is forced through once it has lost LD_MAX_WAIT times.
  assign lbuf_wins = lbuf_valid & (~alu_wen | (wait_cnt == WW'(LD_MAX_WAIT)));
  assign alu_ready = ~lbuf_wins;
  assign ld_ready  = ~lbuf_valid | lbuf_wins;

  always_comb begin
    wb_sel = WB_NONE;
    if (lbuf_wins)    wb_sel = WB_LOAD;
    else if (alu_wen) wb_sel = WB_ALU;
  end

  // Set beats clear so a reissued load to the same rd stays tracked.
  always_comb begin
    busy_next = busy;
    if (reg_write && wb_src_q == WB_LOAD) busy_next[write_index] = 1'b0;
    if (push && ld_rd != '0)              busy_next[ld_rd]       = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      lbuf_valid   <= 1'b0;
      lbuf_rd      <= '0;
      lbuf_data    <= '0;
      wait_cnt     <= '0;
      reg_write    <= 1'b0;
      write_index  <= '0;
      write_data   <= '0;
      wb_src_q     <= WB_NONE;
      busy         <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (pop) begin
        lbuf_valid <= 1'b1;
        lbuf_rd    <= fifo_head;
        lbuf_data  <= ld_data;
      end else if (lbuf_wins) begin
        lbuf_valid <= 1'b0;
      end

      if (!lbuf_valid || lbuf_wins) wait_cnt <= '0;
      else                          wait_cnt <= wait_cnt + 1'b1;

      // x0 destinations still consume the port slot but never write.
      case (wb_sel)
        WB_LOAD: begin
          reg_write   <= (lbuf_rd != '0);
          write_index <= lbuf_rd;
          write_data  <= lbuf_data;
        end
        WB_ALU: begin
          reg_write   <= (alu_rd != '0);
          write_index <= alu_rd;
          write_data  <= alu_wdata;
        end
        default: reg_write <= 1'b0;
      endcase
      wb_src_q <= wb_sel;

      busy <= busy_next;
      if (ld_done && fifo_empty) protocol_err <= 1'b1;
    end
  end

  assign busy_vec = busy;
  assign hazard   = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd];

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter.
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        RST;
  logic        alu_wen;
  logic [4:0]  alu_rd;
  logic [31:0] alu_wdata;
  logic        alu_ready;
  logic        ld_issue;
  logic [4:0]  ld_rd;
  logic        ld_issue_ready;
  logic        ld_done;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        hazard;
  logic        reg_write;
  logic [4:0]  write_index;
  logic [31:0] write_data;
  logic [31:0] busy_vec;
  logic        protocol_err;

  int checks = 0;
  int errors = 0;

  writeback_arbiter dut (
    .clk            (clk),
    .RST            (RST),
    .alu_wen        (alu_wen),
    .alu_rd         (alu_rd),
    .alu_wdata      (alu_wdata),
    .alu_ready      (alu_ready),
    .ld_issue       (ld_issue),
    .ld_rd          (ld_rd),
    .ld_issue_ready (ld_issue_ready),
    .ld_done        (ld_done),
    .ld_data        (ld_data),
    .ld_ready       (ld_ready),
    .dec_rs1        (dec_rs1),
    .dec_rs2        (dec_rs2),
    .dec_rd         (dec_rd),
    .hazard         (hazard),
    .reg_write      (reg_write),
    .write_index    (write_index),
    .write_data     (write_data),
    .busy_vec       (busy_vec),
    .protocol_err   (protocol_err)
  );

  always #5 clk = ~clk;

  // Inputs change 1 ns after a rising edge; checks happen 2 ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_wen = 0; alu_rd = 0; alu_wdata = 0;
    ld_issue = 0; ld_rd = 0; ld_done = 0; ld_data = 0;
    dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
  endtask

  task automatic do_reset();
    idle();
    RST = 1;
    cyc();
    cyc();
    RST = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    checks++; if (reg_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_reg_write got %b expected 0", reg_write); end
    checks++; if (write_index !== 5'd0) begin errors++; $display("[TB] FAIL reset_write_index got %0d expected 0", write_index); end
    checks++; if (write_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_write_data got %h expected 0", write_data); end
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("[TB] FAIL reset_busy_vec got %h expected 0", busy_vec); end
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_protocol_err got %b expected 0", protocol_err); end
    checks++; if ({ld_issue_ready, ld_ready, alu_ready, hazard} !== 4'b1110) begin errors++; $display("[TB] FAIL reset_comb_outputs got %b expected 1110", {ld_issue_ready, ld_ready, alu_ready, hazard}); end
    cyc();
  endtask

  task automatic test_alu_write();
    alu_wen = 1; alu_rd = 5; alu_wdata = 32'hDEADBEEF;
    #2;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("[TB] FAIL alu_ready got %b expected 1", alu_ready); end
    cyc();
    alu_wen = 0;
    #2;
    checks++; if ({reg_write, write_index, write_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin errors++; $display("[TB] FAIL alu_write got %b/%0d/%h expected 1/5/deadbeef", reg_write, write_index, write_data); end
    cyc();
    #2;
    checks++; if (reg_write !== 1'b0) begin errors++; $display("[TB] FAIL alu_write_idle got %b expected 0", reg_write); end
    cyc();
  endtask

  task automatic test_load_hazard();
    ld_issue = 1; ld_rd = 7;
    #2;
    checks++; if (ld_issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL ld_issue_ready got %b expected 1", ld_issue_ready); end
    cyc();
    ld_issue = 0; dec_rs1 = 7;
    #2;
    checks++; if (hazard !== 1'b1 || busy_vec[7] !== 1'b1) begin errors++; $display("[TB] FAIL raw_hazard got %b/%b expected 1/1", hazard, busy_vec[7]); end
    dec_rs1 = 0; dec_rd = 7;
    #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("[TB] FAIL waw_hazard got %b expected 1", hazard); end
    dec_rd = 0; dec_rs1 = 7;
    cyc();
    ld_done = 1; ld_data = 32'h1234;
    #2;
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL ld_ready got %b expected 1", ld_ready); end
    cyc();
    ld_done = 0; ld_data = 0;
    #2;
    checks++; if (reg_write !== 1'b0 || hazard !== 1'b1) begin errors++; $display("[TB] FAIL load_k1 got rw=%b hz=%b expected 0/1", reg_write, hazard); end
    cyc();
    #2;
    checks++; if ({reg_write, write_index, write_data} !== {1'b1, 5'd7, 32'h1234} || hazard !== 1'b1) begin errors++; $display("[TB] FAIL load_k2 got %b/%0d/%h hz=%b expected 1/7/1234 hz=1", reg_write, write_index, write_data, hazard); end
    cyc();
    #2;
    checks++; if (hazard !== 1'b0 || busy_vec[7] !== 1'b0 || reg_write !== 1'b0) begin errors++; $display("[TB] FAIL load_k3 got hz=%b busy=%b rw=%b expected 0/0/0", hazard, busy_vec[7], reg_write); end
    dec_rs1 = 0;
    cyc();
  endtask

  task automatic test_contention();
    ld_issue = 1; ld_rd = 9;
    cyc();
    ld_issue = 0; ld_done = 1; ld_data = 32'hAAAA5555;
    cyc();
    ld_done = 0; alu_wen = 1; alu_rd = 3;
    for (int i = 0; i < 4; i++) begin
      alu_wdata = 32'h100 + i;
      #2;
      checks++; if (alu_ready !== (i < 3)) begin errors++; $display("[TB] FAIL contention_alu_ready[%0d] got %b expected %b", i, alu_ready, (i < 3)); end
      if (i > 0) begin
        checks++; if ({reg_write, write_index, write_data} !== {1'b1, 5'd3, 32'h100 + i - 1}) begin errors++; $display("[TB] FAIL contention_alu_write[%0d] got %b/%0d/%h expected 1/3/%h", i, reg_write, write_index, write_data, 32'h100 + i - 1); end
      end
      cyc();
    end
    #2;
    checks++; if ({reg_write, write_index, write_data} !== {1'b1, 5'd9, 32'hAAAA5555} || alu_ready !== 1'b1) begin errors++; $display("[TB] FAIL contention_load_write got %b/%0d/%h ar=%b expected 1/9/aaaa5555 ar=1", reg_write, write_index, write_data, alu_ready); end
    cyc();
    alu_wen = 0;
    #2;
    checks++; if ({reg_write, write_index, write_data} !== {1'b1, 5'd3, 32'h103} || busy_vec[9] !== 1'b0) begin errors++; $display("[TB] FAIL contention_resume got %b/%0d/%h busy9=%b expected 1/3/103 busy9=0", reg_write, write_index, write_data, busy_vec[9]); end
    cyc();
    idle();
    cyc();
  endtask

  task automatic test_full_queue();
    for (int i = 1; i <= 4; i++) begin
      ld_issue = 1; ld_rd = 5'(i);
      #2;
      checks++; if (ld_issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_issue_ready[%0d] got %b expected 1", i, ld_issue_ready); end
      cyc();
    end
    ld_rd = 5;
    #2;
    checks++; if (ld_issue_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_issue_ready_at_full got %b expected 0", ld_issue_ready); end
    cyc();
    ld_issue = 0;
    #2;
    checks++; if (busy_vec !== 32'h0000_001E) begin errors++; $display("[TB] FAIL full_busy_vec got %h expected 0000001e", busy_vec); end
    for (int i = 0; i < 6; i++) begin
      ld_done = (i < 4);
      ld_data = 32'h11 + i;
      #2;
      if (i < 4) begin
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_ld_ready[%0d] got %b expected 1", i, ld_ready); end
      end
      if (i >= 2) begin
        checks++; if ({reg_write, write_index, write_data} !== {1'b1, 5'(i - 1), 32'h11 + i - 2}) begin errors++; $display("[TB] FAIL full_return_order[%0d] got %b/%0d/%h expected 1/%0d/%h", i, reg_write, write_index, write_data, i - 1, 32'h11 + i - 2); end
      end
      cyc();
    end
    ld_done = 0;
    #2;
    checks++; if (busy_vec !== 32'h0 || protocol_err !== 1'b0) begin errors++; $display("[TB] FAIL full_drained got busy=%h perr=%b expected 0/0", busy_vec, protocol_err); end
    cyc();
  endtask

  task automatic test_edge_cases();
    alu_wen = 1; alu_rd = 0; alu_wdata = 32'hFFFF_FFFF;
    #2;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("[TB] FAIL x0_alu_ready got %b expected 1", alu_ready); end
    cyc();
    alu_wen = 0;
    #2;
    checks++; if (reg_write !== 1'b0) begin errors++; $display("[TB] FAIL x0_no_write got %b expected 0", reg_write); end
    ld_done = 1; ld_data = 32'hBAD0BAD0;
    cyc();
    ld_done = 0;
    #2;
    checks++; if (protocol_err !== 1'b1 || busy_vec !== 32'h0) begin errors++; $display("[TB] FAIL empty_done_err got perr=%b busy=%h expected 1/0", protocol_err, busy_vec); end
    cyc();
    #2;
    checks++; if (reg_write !== 1'b0 || protocol_err !== 1'b1) begin errors++; $display("[TB] FAIL empty_done_no_write got rw=%b perr=%b expected 0/1", reg_write, protocol_err); end
    cyc();
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 20; i <= 22; i++) begin
      ld_issue = 1; ld_rd = 5'(i);
      cyc();
    end
    ld_issue = 0; ld_done = 1; ld_data = 32'h5A5A; alu_wen = 1; alu_rd = 0;
    cyc();
    ld_done = 0;
    #2;
    checks++; if (ld_ready !== 1'b0 || busy_vec !== 32'h0070_0000) begin errors++; $display("[TB] FAIL pre_reset_state got ldr=%b busy=%h expected 0/00700000", ld_ready, busy_vec); end
    RST = 1;
    cyc();
    RST = 0; alu_wen = 0; dec_rs1 = 20; dec_rs2 = 21; dec_rd = 22;
    #2;
    checks++; if (busy_vec !== 32'h0 || reg_write !== 1'b0 || ld_issue_ready !== 1'b1 || hazard !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset got busy=%h rw=%b lir=%b hz=%b expected 0/0/1/0", busy_vec, reg_write, ld_issue_ready, hazard); end
    cyc();
    #2;
    checks++; if (reg_write !== 1'b0 || protocol_err !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_lbuf_dropped got rw=%b perr=%b expected 0/0", reg_write, protocol_err); end
    ld_done = 1;
    cyc();
    ld_done = 0;
    #2;
    checks++; if (protocol_err !== 1'b1 || reg_write !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_done_err got perr=%b rw=%b expected 1/0", protocol_err, reg_write); end
    cyc();
  endtask

  initial begin
    RST = 1;
    idle();
    test_reset();
    test_alu_write();
    test_load_hazard();
    test_contention();
    test_full_queue();
    test_edge_cases();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Shares the register file's single write port between the ALU writeback path and variable-latency load returns. Tracks in-flight load destinations in a scoreboard and raises a decode hazard on RAW/WAW conflicts. Sits between execute/memory stages and the register file write port: it drives `reg_write`, `write_index` and `write_data`, and the decode stage reads its `hazard` output.

## Interface
- `LDQ_DEPTH`, 4: max outstanding loads (power of two, ≥2).
- `LD_MAX_WAIT`, 3: cycles a buffered load may lose arbitration before it is forced to win.

Ports:
- `clk` in 1: single clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `alu_wen` in 1: ALU result valid.
- `alu_rd` in 5: ALU destination.
- `alu_wdata` in 32: ALU result.
- `alu_ready` out 1: ALU result accepted this cycle.
- `ld_issue` in 1: load issued.
- `ld_rd` in 5: load destination.
- `ld_issue_ready` out 1: tag queue can accept a new load.
- `ld_done` in 1: memory returns data for the oldest load.
- `ld_data` in 32: load data.
- `ld_ready` out 1: return accepted.
- `dec_rs1`, `dec_rs2`, `dec_rd` in 5 each: decode-stage indices.
- `hazard` out 1: decode must stall.
- `reg_write` out 1, `write_index` out 5, `write_data` out 32: register file write port (registered).
- `busy_vec` out 32: scoreboard.
- `protocol_err` out 1: sticky error flag.

## Operation
- **Tag FIFO:** holds `rd` of outstanding loads, in order.
  - Push on `ld_issue & ld_issue_ready`.
  - Pop on `ld_done & ld_ready`.
  - `ld_issue_ready = count < LDQ_DEPTH`.
  - Simultaneous push and pop leaves `count` unchanged. At full, a same-cycle pop does not raise `ld_issue_ready`.
- **Scoreboard:**
  - Set `busy[ld_rd]` on an accepted issue when `ld_rd != 0`.
  - Clear `busy[write_index]` at the end of a cycle where `reg_write = 1` for a load write.
  - If set and clear hit the same index in the same cycle, set wins.
  - `busy[0]` is always 0.
- **Load buffer (1 entry, `lbuf`):** holds {rd from FIFO head, `ld_data`} on an accepted return.
  - `ld_ready = !lbuf_valid | lbuf_wins`.
- **Arbitration (each cycle):**
  - `lbuf_wins = lbuf_valid & (!alu_wen | wait_cnt == LD_MAX_WAIT)`.
  - `alu_ready = !lbuf_wins`.
  - The winner is loaded into the write-port registers.
  - `wait_cnt` increments while `lbuf_valid` and the buffer loses; it resets to 0 whenever `lbuf` drains.
- **x0 writes:** an ALU write to rd = 0 is accepted (`alu_ready = 1`), but `reg_write` stays 0 for it.
- **Hazard:** `hazard = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd]`. Index 0 never hazards.
- **Protocol errors:** `ld_done` with the FIFO empty is ignored and sets `protocol_err`, which stays set until `RST`.
- **Reset** (any time, including with loads in flight): FIFO flushed, `lbuf` discarded, `busy_vec = 0`, `wait_cnt = 0`, `protocol_err = 0`, `reg_write = 0`, `write_index = 0`, `write_data = 0`.
- **Combinational outputs after reset:** `ld_issue_ready = 1`, `ld_ready = 1`, `alu_ready = 1`, `hazard = 0`.

## Timing
- ALU accepted at edge k → `reg_write = 1` during cycle k+1 → register file commits at edge k+2.
- Load return accepted at edge k → `lbuf_valid` in cycle k+1.
  - With no ALU contention, `reg_write` is high in k+2.
  - `busy` clears at edge k+3, so `hazard` on that rd drops in cycle k+3.
- Worst-case starvation of a buffered load: `LD_MAX_WAIT` cycles, then the ALU sees `alu_ready = 0` for one cycle.
- Steady-state load throughput: 1 per cycle (buffer drains and refills in the same cycle).
- `hazard`, `alu_ready`, `ld_ready` and `ld_issue_ready` are combinational from state and current inputs. There are no input-to-output paths through `write_*`.

## Structure
- `cpu_pkg` holds:
  - types `word_t` and `reg_idx_t` (5 bits);
  - constants `LDQ_DEPTH_DEF` and `LD_MAX_WAIT_DEF`;
  - a `wb_src_t` enum {`WB_NONE`, `WB_ALU`, `WB_LOAD`} for the winner select.
- Sub-module `ld_tag_fifo`: parameterized depth-N `reg_idx_t` FIFO with `push`, `pop`, `head`, `count`, `full` and `empty`.

## Test plan
- **ALU write:** `alu_wen`, rd = 5, data 0xDEADBEEF → `reg_write = 1`, `write_index = 5`, `write_data = 0xDEADBEEF` one cycle later; `alu_ready = 1`.
- **Load and RAW hazard:** issue load rd = 7; decode rs1 = 7 → `hazard = 1`, `busy_vec[7] = 1`. Return 0x1234 with no ALU traffic → write idx 7 in cycle k+2; `hazard = 0` from k+3.
- **Contention:** `alu_wen` held every cycle while `lbuf` is valid → ALU wins 3 cycles; 4th cycle `alu_ready = 0` and the load writes; ALU resumes next cycle.
- **Full queue:** issue 4 loads (rd 1–4) → `ld_issue_ready = 0`; a 5th issue is not taken. Returns write rd 1, 2, 3, 4 in order.
- **Edge cases:** ALU rd = 0 → no `reg_write`. `ld_done` with empty FIFO → `protocol_err = 1`, no write, `busy_vec` unchanged.
- **Mid-operation reset:** 2 loads outstanding and `lbuf` valid, pulse `RST` one cycle → `busy_vec = 0`, `reg_write = 0`, `ld_issue_ready = 1`; a later `ld_done` sets `protocol_err`.
